// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, operand forwarding and stall/flush event counters
//
// Purpose:
//   Tracks a shadow copy of the register usage of the instructions in the
//   execute, memory and writeback slots. From those slots and the decode-stage
//   register fields it produces the execute-stage forwarding selects and the
//   fetch/decode stall and decode/execute flush controls. It also counts stall
//   cycles and taken-branch cycles for performance debug.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D, RdD           register fields of the instruction in decode
//   RegWriteD, ResultSrcD     decode instruction writes Rd / is a load
//   PCSrcE                    taken branch resolved in execute
//   ForwardA_E, ForwardB_E    00 RD1/RD2_E, 01 ResultW, 10 ALUResultM
//   StallF, StallD            hold PC / hold IF-ID register
//   FlushD, FlushE            clear IF-ID / clear ID-EX register
//   StallCount, FlushCount    saturating event counters
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic             ResultSrcD,
  input  logic             PCSrcE,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Shadow pipeline slots
  logic [4:0] e_rs1;
  logic [4:0] e_rs2;
  logic [4:0] e_rd;
  logic       e_regwrite;
  logic       e_load;
  logic [4:0] m_rd;
  logic       m_regwrite;
  logic [4:0] w_rd;
  logic       w_regwrite;

  logic       lw_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_rd       <= '0;
      e_regwrite <= 1'b0;
      e_load     <= 1'b0;
      m_rd       <= '0;
      m_regwrite <= 1'b0;
      w_rd       <= '0;
      w_regwrite <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      w_rd       <= m_rd;
      w_regwrite <= m_regwrite;
      m_rd       <= e_rd;
      m_regwrite <= e_regwrite;
      if (FlushE) begin
        // Bubble: a slot that writes nothing and loads nothing
        e_rs1      <= '0;
        e_rs2      <= '0;
        e_rd       <= '0;
        e_regwrite <= 1'b0;
        e_load     <= 1'b0;
      end else begin
        e_rs1      <= Rs1D;
        e_rs2      <= Rs2D;
        e_rd       <= RdD;
        e_regwrite <= RegWriteD;
        e_load     <= ResultSrcD;
      end
      if (StallD && StallCount != CNT_MAX) begin
        StallCount <= StallCount + CNT_ONE;
      end
      if (PCSrcE && FlushCount != CNT_MAX) begin
        FlushCount <= FlushCount + CNT_ONE;
      end
    end
  end

  always_comb begin
    // Memory stage is younger than writeback, so it wins when both match
    ForwardA_E = 2'b00;
    if (m_regwrite && m_rd != 5'd0 && m_rd == e_rs1) begin
      ForwardA_E = 2'b10;
    end else if (w_regwrite && w_rd != 5'd0 && w_rd == e_rs1) begin
      ForwardA_E = 2'b01;
    end

    ForwardB_E = 2'b00;
    if (m_regwrite && m_rd != 5'd0 && m_rd == e_rs2) begin
      ForwardB_E = 2'b10;
    end else if (w_regwrite && w_rd != 5'd0 && w_rd == e_rs2) begin
      ForwardB_E = 2'b01;
    end

    // A taken branch squashes the decode consumer anyway, so it cancels the stall
    lw_stall = e_load && (e_rd != 5'd0) && ((e_rd == Rs1D) || (e_rd == Rs2D)) && !PCSrcE;

    StallF = lw_stall;
    StallD = lw_stall;
    FlushD = PCSrcE;
    FlushE = lw_stall | PCSrcE;
  end

endmodule
